ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Single-clock round-robin controller that shares the write port and the read port of one simple dual-port RAM (1-cycle registered read) among NUM_REQ requesters, e.g. the switch ingress/egress ports using a shared packet buffer. It drives the RAM ports from registers and returns tagged read responses with fixed latency. It also resolves same-cycle read/write address collisions so that a read always returns the newest written data.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_WIDTH, 8, RAM address width
WORD_WIDTH, 8, RAM word width
ID_WIDTH, $clog2(NUM_REQ), localparam, requester index width

Ports:
clk  in  1  single clock; RAM instance is clocked with the same clk on both ports
rst_n  in  1  asynchronous active-low reset
wr_req_valid  in  NUM_REQ  per-requester write request
wr_req_ready  out  NUM_REQ  write grant, one-hot or zero
wr_req_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses, requester i at slice i
wr_req_data  in  NUM_REQ*WORD_WIDTH  packed write data
rd_req_valid  in  NUM_REQ  per-requester read request
rd_req_ready  out  NUM_REQ  read grant, one-hot or zero
rd_req_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses
rd_rsp_valid  out  NUM_REQ  one-hot read response strobe, no backpressure
rd_rsp_data  out  WORD_WIDTH  response data, shared by all requesters
ram_wren  out  1  to RAM wren
ram_write_addr  out  ADDR_WIDTH  to RAM write_addr
ram_write_data  out  WORD_WIDTH  to RAM write_data
ram_rden  out  1  to RAM rden
ram_read_addr  out  ADDR_WIDTH  to RAM read_addr
ram_read_data  in  WORD_WIDTH  from RAM read_data

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, ram_wren=ram_rden=0, ram_* addr/data=0, rd_rsp_valid=0, ID pipeline cleared. Any read in flight is discarded; no rd_rsp_valid fires after release.
- Arbitration: the write and read arbiters are independent and combinational. The winner is the lowest index >= ptr (wrapping modulo NUM_REQ) with valid=1. ready[winner]=1; all other ready bits are 0. ready may depend on valid. A transfer occurs when valid&ready.
- Pointer: after a transfer, ptr <= winner+1, wrapping from NUM_REQ-1 to 0. With no transfer, ptr holds.
- Write path: a transfer in cycle n sets ram_wren=1 with the registered addr/data in cycle n+1. RAM is updated at the end of n+1. Without a transfer, ram_wren=0 and addr/data hold their last values.
- Read path: a transfer in cycle n sets ram_rden=1 and ram_read_addr in cycle n+1. In cycle n+2, rd_rsp_valid[id]=1 and rd_rsp_data=ram_read_data. Latency is exactly 2; throughput is 1 read per cycle. Responses come back in grant order. A 2-stage valid/ID shift register tracks the tag.
- Collision: if a write transfer and the read winner target the same address in the same cycle, all rd_req_ready bits are 0 that cycle and rd_ptr holds. The read is granted the following cycle (if still valid) and returns the new data. Write wins. Read/write transfers to different addresses in the same cycle both proceed.
- A write accepted in cycle n-1 followed by a read of the same address in cycle n needs no stall, because the RAM write lands one cycle before the read.
- rd_rsp_data outside rd_rsp_valid is don't-care. The bench must check it only when valid.
- Requesters must hold addr/data stable while valid && !ready. The arbiter does not require valid to stay high.

Decomposition:
- Shared package switch_ram_pkg: helper function for ID_WIDTH, and a default NUM_REQ constant.
- One sub-module, rr_arbiter (params N; ports clk, rst_n, req, advance, grant, grant_id), instantiated once for writes and once for reads. Collision masking lives in the top level via the read instance's advance input and ready gating.

Test Plan (NUM_REQ=4, ADDR_WIDTH=8, WORD_WIDTH=8, behavioural RAM attached):
1. Reset -> all outputs 0. Release rst_n with no requests -> ram_wren/ram_rden stay 0 and no rd_rsp_valid.
2. wr_req_valid=4'b0001, addr 0x10, data 0xA5 -> wr_req_ready=4'b0001 the same cycle. Next cycle ram_wren=1, ram_write_addr=0x10, ram_write_data=0xA5, for exactly one cycle.
3. After (2), read from req1 at addr 0x10 -> rd_req_ready=4'b0010. Two cycles later rd_rsp_valid=4'b0010 and rd_rsp_data=0xA5.
4. All four read valids held high for 5 cycles from rd_ptr=0, addresses 0x00..0x03 preloaded with 0x11..0x44 -> grants 0,1,2,3,0. Responses are 0x11,0x22,0x33,0x44,0x11, each on the matching one-hot valid.
5. Same cycle: write from req2 (0x33 <- 0x5C) and read from req0 (0x33), RAM preloaded with 0x00 -> write granted and read ready=0. Read granted the next cycle and returns 0x5C.
6. Read granted, then rst_n pulsed low for one cycle before its response -> no rd_rsp_valid afterwards. Next arbitration starts from index 0.

Source files
------------

// File: rtl/switch_ram_pkg.sv
// Shared definitions for the packet-buffer RAM port arbiter and its round-robin sub-arbiters.
package switch_ram_pkg;

    localparam int DEFAULT_NUM_REQ = 4;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or after ptr,
// and moves ptr past the winner only when the caller reports that the grant was taken.
module rr_arbiter
    import switch_ram_pkg::*;
#(
    parameter  int N   = DEFAULT_NUM_REQ,
    localparam int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the write and read ports of one simple dual-port RAM (registered read) among
// NUM_REQ requesters, returning tagged read responses with a fixed two-cycle latency.
module ram_port_arbiter
    import switch_ram_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_REQ-1:0]            wr_req_valid,
    output logic [NUM_REQ-1:0]            wr_req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] wr_req_data,

    input  logic [NUM_REQ-1:0]            rd_req_valid,
    output logic [NUM_REQ-1:0]            rd_req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr,
    output logic [NUM_REQ-1:0]            rd_rsp_valid,
    output logic [WORD_WIDTH-1:0]         rd_rsp_data,

    output logic                          ram_wren,
    output logic [ADDR_WIDTH-1:0]         ram_write_addr,
    output logic [WORD_WIDTH-1:0]         ram_write_data,
    output logic                          ram_rden,
    output logic [ADDR_WIDTH-1:0]         ram_read_addr,
    input  logic [WORD_WIDTH-1:0]         ram_read_data
);

    localparam int ID_WIDTH = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]    wr_grant;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [NUM_REQ-1:0]    rd_grant;
    logic [ID_WIDTH-1:0]   rd_id;
    logic                  wr_any;
    logic                  rd_any;
    logic                  collision;
    logic                  rd_fire;
    logic [ADDR_WIDTH-1:0] wr_addr_sel;
    logic [WORD_WIDTH-1:0] wr_data_sel;
    logic [ADDR_WIDTH-1:0] rd_addr_sel;

    logic                  vld_p1;
    logic [ID_WIDTH-1:0]   id_p1;
    logic                  vld_p2;
    logic [ID_WIDTH-1:0]   id_p2;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (wr_req_valid),
        .advance  (wr_any),
        .grant    (wr_grant),
        .grant_id (wr_id)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (rd_req_valid),
        .advance  (rd_fire),
        .grant    (rd_grant),
        .grant_id (rd_id)
    );

    // Stage p0: select the winners' request fields and resolve address collisions.
    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == wr_id) begin
                wr_addr_sel = wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = wr_req_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
            if (ID_WIDTH'(i) == rd_id) begin
                rd_addr_sel = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign wr_any = |wr_grant;
    assign rd_any = |rd_grant;

    // The RAM reads old data on a same-cycle same-address write, so the read waits a cycle.
    assign collision    = wr_any && rd_any && (wr_addr_sel == rd_addr_sel);
    assign rd_fire      = rd_any && !collision;
    assign wr_req_ready = wr_grant;
    assign rd_req_ready = collision ? '0 : rd_grant;

    // Stage p1: registered RAM port drive plus the read tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wren       <= 1'b0;
            ram_write_addr <= '0;
            ram_write_data <= '0;
            vld_p1         <= 1'b0;
            id_p1          <= '0;
            ram_read_addr  <= '0;
        end else begin
            ram_wren <= wr_any;
            if (wr_any) begin
                ram_write_addr <= wr_addr_sel;
                ram_write_data <= wr_data_sel;
            end
            vld_p1 <= rd_fire;
            if (rd_fire) begin
                id_p1         <= rd_id;
                ram_read_addr <= rd_addr_sel;
            end
        end
    end

    assign ram_rden = vld_p1;

    // Stage p2: tag aligned with the RAM's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            id_p2  <= '0;
        end else begin
            vld_p2 <= vld_p1;
            id_p2  <= id_p1;
        end
    end

    always_comb begin
        rd_rsp_valid = '0;
        if (vld_p2) begin
            rd_rsp_valid[id_p2] = 1'b1;
        end
    end

    assign rd_rsp_data = ram_read_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, reference arbitration model, scoreboard monitor.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    wv, rv;
    logic [N-1:0]    wr_req_ready, rd_req_ready, rd_rsp_valid;
    logic [N*AW-1:0] wr_req_addr, rd_req_addr;
    logic [N*DW-1:0] wr_req_data;
    logic [DW-1:0]   rd_rsp_data;
    logic            ram_wren, ram_rden;
    logic [AW-1:0]   ram_write_addr, ram_read_addr;
    logic [DW-1:0]   ram_write_data, ram_read_data;

    logic [AW-1:0]   wa [N];
    logic [DW-1:0]   wd [N];
    logic [AW-1:0]   ra [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign wr_req_addr[g*AW +: AW] = wa[g];
        assign wr_req_data[g*DW +: DW] = wd[g];
        assign rd_req_addr[g*AW +: AW] = ra[g];
    end

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WORD_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req_valid   (wv),
        .wr_req_ready   (wr_req_ready),
        .wr_req_addr    (wr_req_addr),
        .wr_req_data    (wr_req_data),
        .rd_req_valid   (rv),
        .rd_req_ready   (rd_req_ready),
        .rd_req_addr    (rd_req_addr),
        .rd_rsp_valid   (rd_rsp_valid),
        .rd_rsp_data    (rd_rsp_data),
        .ram_wren       (ram_wren),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_rden       (ram_rden),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural simple dual-port RAM, read-first on a same-cycle collision.
    logic          mem_clear;
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (ram_rden) ram_read_data <= mem[ram_read_addr];
            if (ram_wren) mem[ram_write_addr] <= ram_write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  oh;
    } exp_t;

    exp_t wr_q[$];
    exp_t rden_q[$];
    exp_t rsp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    int wptr, rptr, last_ww, last_rw;

    task automatic model_cycle(input bit dchk, input logic [N-1:0] ewr, input logic [N-1:0] erd);
        int ww, rw, idx;
        logic [N-1:0] mwr, mrd;
        exp_t e;
        ww = -1;
        rw = -1;
        for (int k = 0; k < N; k++) begin
            idx = (wptr + k) % N;
            if (ww < 0 && wv[idx]) ww = idx;
            idx = (rptr + k) % N;
            if (rw < 0 && rv[idx]) rw = idx;
        end
        if (ww >= 0 && rw >= 0 && wa[ww] == ra[rw]) rw = -1;
        mwr = (ww >= 0) ? N'(1 << ww) : '0;
        mrd = (rw >= 0) ? N'(1 << rw) : '0;
        chk("wr_ready", 32'(wr_req_ready), 32'(mwr));
        chk("rd_ready", 32'(rd_req_ready), 32'(mrd));
        if (dchk) begin
            chk("wr_ready_dir", 32'(wr_req_ready), 32'(ewr));
            chk("rd_ready_dir", 32'(rd_req_ready), 32'(erd));
        end
        if (rw >= 0) begin
            e.cyc = cyc + 1; e.a = ra[rw]; e.d = '0; e.oh = mrd;
            rden_q.push_back(e);
            e.cyc = cyc + 2; e.d = ref_mem[ra[rw]];
            rsp_q.push_back(e);
            rptr = (rw + 1) % N;
        end
        if (ww >= 0) begin
            e.cyc = cyc + 1; e.a = wa[ww]; e.d = wd[ww]; e.oh = mwr;
            wr_q.push_back(e);
            ref_mem[wa[ww]] = wd[ww];
            wptr = (ww + 1) % N;
        end
        last_ww = ww;
        last_rw = rw;
    endtask

    task automatic step(input bit dchk, input logic [N-1:0] ewr, input logic [N-1:0] erd);
        @(negedge clk);
        model_cycle(dchk, ewr, erd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        wr_q.delete();
        rden_q.delete();
        rsp_q.delete();
        wptr = 0;
        rptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor
    exp_t          me;
    logic [DW-1:0] last_rsp_data;
    logic [N-1:0]  last_rsp_valid;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                me = wr_q.pop_front();
                chk("ram_wren", 32'(ram_wren), 32'd1);
                chk("ram_write_addr", 32'(ram_write_addr), 32'(me.a));
                chk("ram_write_data", 32'(ram_write_data), 32'(me.d));
            end else begin
                chk("ram_wren_idle", 32'(ram_wren), 32'd0);
            end
            if (rden_q.size() > 0 && rden_q[0].cyc == cyc) begin
                me = rden_q.pop_front();
                chk("ram_rden", 32'(ram_rden), 32'd1);
                chk("ram_read_addr", 32'(ram_read_addr), 32'(me.a));
            end else begin
                chk("ram_rden_idle", 32'(ram_rden), 32'd0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                me = rsp_q.pop_front();
                chk("rd_rsp_valid", 32'(rd_rsp_valid), 32'(me.oh));
                chk("rd_rsp_data", 32'(rd_rsp_data), 32'(me.d));
            end else begin
                chk("rd_rsp_idle", 32'(rd_rsp_valid), 32'd0);
            end
            if (rd_rsp_valid != '0) begin
                last_rsp_data  = rd_rsp_data;
                last_rsp_valid = rd_rsp_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mem_clear = 1'b1;
        wv = '0;
        rv = '0;
        for (int i = 0; i < N; i++) begin
            wa[i] = '0; wd[i] = '0; ra[i] = '0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        wptr = 0; rptr = 0; last_ww = -1; last_rw = -1;
        last_rsp_data = '0; last_rsp_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;

        // 1: reset state, then quiet release
        chk("rst_ram_wren", 32'(ram_wren), 32'd0);
        chk("rst_ram_rden", 32'(ram_rden), 32'd0);
        chk("rst_ram_write_addr", 32'(ram_write_addr), 32'd0);
        chk("rst_ram_write_data", 32'(ram_write_data), 32'd0);
        chk("rst_ram_read_addr", 32'(ram_read_addr), 32'd0);
        chk("rst_rd_rsp_valid", 32'(rd_rsp_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_req_ready), 32'd0);
        chk("rst_rd_ready", 32'(rd_req_ready), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // 2: single write
        wv = 4'b0001; wa[0] = 8'h10; wd[0] = 8'hA5;
        step(1'b1, 4'b0001, 4'b0000);
        wv = '0;
        idle(2);

        // 3: read it back from requester 1
        rv = 4'b0010; ra[1] = 8'h10;
        step(1'b1, 4'b0000, 4'b0010);
        rv = '0;
        idle(3);
        chk("t3_rsp_data", 32'(last_rsp_data), 32'hA5);
        chk("t3_rsp_valid", 32'(last_rsp_valid), 32'b0010);

        // 4: preload, reset pointers, four-way read contention
        for (int i = 0; i < 4; i++) begin
            wv = 4'b0001; wa[0] = 8'(i); wd[0] = 8'(8'h11 * (i + 1));
            step(1'b0, '0, '0);
        end
        wv = '0;
        idle(3);
        reset_pulse();
        rv = 4'b1111;
        for (int i = 0; i < 4; i++) ra[i] = 8'(i);
        step(1'b1, 4'b0000, 4'b0001);
        step(1'b1, 4'b0000, 4'b0010);
        step(1'b1, 4'b0000, 4'b0100);
        step(1'b1, 4'b0000, 4'b1000);
        step(1'b1, 4'b0000, 4'b0001);
        rv = '0;
        idle(3);
        chk("t4_last_rsp_data", 32'(last_rsp_data), 32'h11);

        // 5: same-address write/read collision
        wv = 4'b0001; wa[0] = 8'h33; wd[0] = 8'h00;
        step(1'b1, 4'b0001, 4'b0000);
        wv = '0;
        idle(1);
        wv = 4'b0100; wa[2] = 8'h33; wd[2] = 8'h5C;
        rv = 4'b0001; ra[0] = 8'h33;
        step(1'b1, 4'b0100, 4'b0000);
        wv = '0;
        step(1'b1, 4'b0000, 4'b0001);
        rv = '0;
        idle(3);
        chk("t5_rsp_data", 32'(last_rsp_data), 32'h5C);
        chk("t5_rsp_valid", 32'(last_rsp_valid), 32'b0001);

        // 6: reset while a read is in flight
        rv = 4'b0100; ra[2] = 8'h05;
        step(1'b1, 4'b0000, 4'b0100);
        rv = '0;
        reset_pulse();
        idle(4);
        rv = 4'b1111;
        step(1'b1, 4'b0000, 4'b0001);
        rv = '0;
        idle(3);

        // Randomized contention with hold-until-granted requesters
        last_ww = -1;
        last_rw = -1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(wv[i] && last_ww != i)) begin
                    wv[i] = 1'($urandom_range(0, 1));
                    wa[i] = 8'($urandom_range(0, 7));
                    wd[i] = 8'($urandom);
                end
                if (!(rv[i] && last_rw != i)) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ra[i] = 8'($urandom_range(0, 7));
                end
            end
            step(1'b0, '0, '0);
        end
        wv = '0;
        rv = '0;
        idle(4);
        chk("drain_wr_q", 32'(wr_q.size()), 32'd0);
        chk("drain_rden_q", 32'(rden_q.size()), 32'd0);
        chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
